// File: rtl/commfifo_uart_pkg.sv
// commfifo_uart_pkg: shared state encodings and 8N1 frame constants for the UART bridge
package commfifo_uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
endpackage

// File: rtl/commfifo_uart_rx.sv
// commfifo_uart_rx: synchronised 8N1 receiver producing FIFO push strobes and sticky error flags
module commfifo_uart_rx
    import commfifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_not_full,
    input  logic       i_err_clr,
    output logic       o_write,
    output logic [7:0] o_data,
    output logic       o_overrun,
    output logic       o_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] BIT_MAX = 3'(DATA_BITS - 1);

    rx_state_t r_state, w_nxt;
    logic [1:0] r_sync;
    logic r_rxs_d;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic w_rxs, w_tick, w_stop;

    assign w_rxs = r_sync[1];
    assign w_tick = r_cnt == ((r_state == RX_START) ? HALF_MAX : CNT_MAX);
    assign w_stop = (r_state == RX_STOP) && w_tick;

    // Next-state: start-bit midpoint check, eight data samples, stop sample, break wait
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            RX_IDLE:  if (r_rxs_d && !w_rxs) w_nxt = RX_START;
            RX_START: if (w_tick) w_nxt = w_rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_bit == BIT_MAX) w_nxt = RX_STOP;
            RX_STOP:  if (w_tick) w_nxt = w_rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (w_rxs) w_nxt = RX_IDLE;
            default:  w_nxt = RX_IDLE;
        endcase
    end

    // Synchroniser, counters, shift register, push strobe and sticky flags (set beats clear)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= RX_IDLE;
            r_sync      <= 2'b11;
            r_rxs_d     <= 1'b1;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_sh        <= '0;
            o_write     <= 1'b0;
            o_data      <= '0;
            o_overrun   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_sync      <= {r_sync[0], i_rx};
            r_rxs_d     <= w_rxs;
            r_cnt       <= (w_tick || w_nxt != r_state || r_state == RX_IDLE || r_state == RX_BREAK) ? '0 : r_cnt + 1'b1;
            r_bit       <= (r_state != RX_DATA) ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
            r_sh        <= (r_state == RX_DATA && w_tick) ? {w_rxs, r_sh[7:1]} : r_sh;
            o_write     <= w_stop && w_rxs && i_not_full;
            o_data      <= (w_stop && w_rxs && i_not_full) ? r_sh : o_data;
            o_overrun   <= (w_stop && w_rxs && !i_not_full) ? 1'b1 : i_err_clr ? 1'b0 : o_overrun;
            o_frame_err <= (w_stop && !w_rxs) ? 1'b1 : i_err_clr ? 1'b0 : o_frame_err;
        end
    end
endmodule

// File: rtl/commfifo_uart.sv
// commfifo_uart: host-side 8N1 UART bridge draining the D2H FIFO to o_tx and filling the H2D FIFO from i_rx
module commfifo_uart
    import commfifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       d2h_host_not_empty,
    input  logic [7:0] d2h_host_data,
    output logic       d2h_host_rd,
    output logic       h2d_host_write,
    output logic [7:0] h2d_host_data,
    input  logic       h2d_host_not_full,
    output logic       o_tx,
    input  logic       i_rx,
    input  logic       i_err_clr,
    output logic       o_rx_overrun,
    output logic       o_rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] BIT_MAX = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);

    tx_state_t r_state, w_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic w_tick, w_rd;

    assign w_tick = r_cnt == CNT_MAX;
    assign d2h_host_rd = w_rd;
    assign o_tx = (r_state == TX_START) ? 1'b0 : (r_state == TX_DATA) ? r_sh[0] : 1'b1;

    // Next-state and pop strobe; the pop is gated by reset so no strobe escapes while held
    always_comb begin
        w_nxt = r_state;
        w_rd  = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_rd  = d2h_host_not_empty && !i_reset;
                w_nxt = d2h_host_not_empty ? TX_START : TX_IDLE;
            end
            TX_START: if (w_tick) w_nxt = TX_DATA;
            TX_DATA:  if (w_tick && r_bit == BIT_MAX) w_nxt = TX_STOP;
            TX_STOP:  if (w_tick && r_bit == STOP_MAX) w_nxt = TX_IDLE;
            default:  w_nxt = TX_IDLE;
        endcase
    end

    // State, bit-period counter, bit index and LSB-first shift register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (r_state == TX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            r_bit   <= (r_state == TX_IDLE || r_state == TX_START) ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
            r_sh    <= w_rd ? d2h_host_data : (r_state == TX_DATA && w_tick) ? {1'b1, r_sh[7:1]} : r_sh;
        end
    end

    commfifo_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .i_not_full  (h2d_host_not_full),
        .i_err_clr   (i_err_clr),
        .o_write     (h2d_host_write),
        .o_data      (h2d_host_data),
        .o_overrun   (o_rx_overrun),
        .o_frame_err (o_rx_frame_err)
    );
endmodule

// File: tb/tb_commfifo_uart.sv
// tb_commfifo_uart: randomized self-checking bench for the UART FIFO bridge against a frame-level model
module tb_commfifo_uart;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d2h_host_not_empty = 1'b0;
    logic [7:0] d2h_host_data = '0;
    logic       d2h_host_rd;
    logic       h2d_host_write;
    logic [7:0] h2d_host_data;
    logic       h2d_host_not_full = 1'b1;
    logic       o_tx;
    logic       i_rx = 1'b1;
    logic       i_err_clr = 1'b0;
    logic       o_rx_overrun;
    logic       o_rx_frame_err;

    int n_checks = 0;
    int n_err = 0;
    int n_wr = 0;
    logic [7:0] last_wr = '0;
    logic exp_ovr = 1'b0;
    logic exp_fe = 1'b0;

    commfifo_uart #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .d2h_host_not_empty (d2h_host_not_empty),
        .d2h_host_data      (d2h_host_data),
        .d2h_host_rd        (d2h_host_rd),
        .h2d_host_write     (h2d_host_write),
        .h2d_host_data      (h2d_host_data),
        .h2d_host_not_full  (h2d_host_not_full),
        .o_tx               (o_tx),
        .i_rx               (i_rx),
        .i_err_clr          (i_err_clr),
        .o_rx_overrun       (o_rx_overrun),
        .o_rx_frame_err     (o_rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (h2d_host_write) begin
            n_wr++;
            last_wr = h2d_host_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic tx_line(input logic [7:0] b, input int k);
        int slot;
        slot = (k - 1) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Caller has just raised not_empty with data=b in the pop cycle; ends at the negedge of the last frame cycle.
    task automatic tx_frame(input logic [7:0] b, input logic [7:0] nb, input logic more);
        int bad;
        bad = 0;
        @(negedge clk);
        check("tx_pop", d2h_host_rd, 1'b1);
        @(posedge clk);
        #1;
        d2h_host_data = nb;
        d2h_host_not_empty = more;
        for (int k = 1; k <= 10 * CPB; k++) begin
            @(negedge clk);
            if (o_tx !== tx_line(b, k) || d2h_host_rd !== 1'b0) bad++;
        end
        check("tx_frame_bad_cycles", bad, 0);
    endtask

    task automatic drive_bit(input logic v);
        i_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input logic nf);
        int w0;
        int exp_w;
        w0 = n_wr;
        h2d_host_not_full = nf;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        if (!stop) repeat (40) @(posedge clk);
        #1;
        i_rx = 1'b1;
        repeat (8) @(posedge clk);
        exp_w = (stop && nf) ? 1 : 0;
        if (stop && !nf) exp_ovr = 1'b1;
        if (!stop) exp_fe = 1'b1;
        @(negedge clk);
        check("rx_writes", n_wr - w0, exp_w);
        if (exp_w == 1) check("rx_data", last_wr, b);
        check("rx_overrun", o_rx_overrun, exp_ovr);
        check("rx_frame_err", o_rx_frame_err, exp_fe);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errs();
        i_err_clr = 1'b1;
        @(posedge clk);
        #1;
        i_err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_fe = 1'b0;
        @(negedge clk);
        check("clr_overrun", o_rx_overrun, exp_ovr);
        check("clr_frame_err", o_rx_frame_err, exp_fe);
    endtask

    initial begin
        logic [7:0] b0, b1;
        int rd_seen, w0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", o_tx, 1'b1);
        check("rst_rd", d2h_host_rd, 1'b0);
        check("rst_wr", h2d_host_write, 1'b0);
        check("rst_hdata", h2d_host_data, 8'h00);
        check("rst_flags", {o_rx_overrun, o_rx_frame_err}, 2'b00);

        repeat (10) @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b1;
        d2h_host_data = 8'hA5;
        tx_frame(8'hA5, 8'h00, 1'b0);
        @(negedge clk);
        check("tx_idle_after", {o_tx, d2h_host_rd}, 2'b10);

        b0 = 8'($urandom);
        b1 = 8'($urandom);
        @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b1;
        d2h_host_data = b0;
        tx_frame(b0, b1, 1'b1);
        tx_frame(b1, 8'h00, 1'b0);
        rd_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d2h_host_rd !== 1'b0 || o_tx !== 1'b1) rd_seen++;
        end
        check("tx_empty_quiet", rd_seen, 0);

        @(posedge clk);
        #1;
        rx_frame(8'h3C, 1'b1, 1'b1);
        rx_frame(8'h55, 1'b1, 1'b0);
        clear_errs();
        rx_frame(8'h81, 1'b0, 1'b1);
        rx_frame(8'h12, 1'b1, 1'b1);
        clear_errs();

        for (int i = 0; i < 8; i++) begin
            rx_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) clear_errs();
        end
        clear_errs();

        w0 = n_wr;
        @(posedge clk);
        #1;
        i_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_rx = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("glitch_writes", n_wr - w0, 0);
        check("glitch_flags", {o_rx_overrun, o_rx_frame_err}, 2'b00);

        @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b1;
        d2h_host_data = 8'hFF;
        fork
            tx_frame(8'hFF, 8'h00, 1'b0);
            rx_frame(8'h00, 1'b1, 1'b1);
        join

        rx_frame(8'h81, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b1;
        d2h_host_data = 8'h00;
        @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("pre_rst_tx_low", o_tx, 1'b0);
        #2;
        rst = 1'b1;
        exp_fe = 1'b0;
        exp_ovr = 1'b0;
        #1;
        check("mid_rst_tx", o_tx, 1'b1);
        check("mid_rst_rd", d2h_host_rd, 1'b0);
        check("mid_rst_wr", h2d_host_write, 1'b0);
        check("mid_rst_flags", {o_rx_overrun, o_rx_frame_err}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d2h_host_rd !== 1'b0 || o_tx !== 1'b1) rd_seen++;
        end
        check("post_rst_quiet", rd_seen, 0);
        @(posedge clk);
        #1;
        d2h_host_not_empty = 1'b1;
        d2h_host_data = 8'h5A;
        tx_frame(8'h5A, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
